// File: rtl/serial_word_receiver_if.sv
// Handshake bundle between the serial bit source / word consumer
// and the serial word receiver.
interface serial_word_receiver_if #(
    parameter int WIDTH = 16
);

    logic             Start;
    logic             SerialIn;
    logic             SerialValid;
    logic             WordReady;
    logic [WIDTH-1:0] ParallelOutput;
    logic             WordValid;
    logic             Busy;
    logic             Overrun;
    logic             ParityError;

    // Bit source and word consumer side
    modport master (
        output Start,
        output SerialIn,
        output SerialValid,
        output WordReady,
        input  ParallelOutput,
        input  WordValid,
        input  Busy,
        input  Overrun,
        input  ParityError
    );

    // Receiver side
    modport slave (
        input  Start,
        input  SerialIn,
        input  SerialValid,
        input  WordReady,
        output ParallelOutput,
        output WordValid,
        output Busy,
        output Overrun,
        output ParityError
    );

endinterface

// File: rtl/serial_word_receiver.sv
// MSB-first serial-to-parallel word receiver with valid/ready output.
// Optional even-parity phase enabled by defining SERIAL_RX_PARITY_EN.
module serial_word_receiver #(
    parameter int WIDTH = 16
) (
    input logic                  clk,
    input logic                  clr,
    serial_word_receiver_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [CW-1:0] PARITY_IDX = CW'(WIDTH);
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t           state;
    logic [CW-1:0]    bitCount;
    logic [WIDTH-1:0] shiftReg;
    logic [WIDTH-1:0] wordReg;
    logic [WIDTH-1:0] shifted;
    logic             wordValid;
    logic             busy;
    logic             overrun;
`ifdef SERIAL_RX_PARITY_EN
    logic             parityAcc;
    logic             parityErr;
`endif

    assign shifted = {shiftReg[WIDTH-2:0], bus.SerialIn};

    // Frame FSM: bit capture, word hold and sticky overrun
    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= IDLE;
            bitCount  <= '0;
            shiftReg  <= '0;
            wordReg   <= '0;
            wordValid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parityAcc <= 1'b0;
            parityErr <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state    <= SHIFT;
                        busy     <= 1'b1;
                        bitCount <= '0;
                        shiftReg <= '0;
`ifdef SERIAL_RX_PARITY_EN
                        parityAcc <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (bus.Start) begin
                        // Restart: the bit in this cycle is dropped
                        bitCount <= '0;
                        shiftReg <= '0;
`ifdef SERIAL_RX_PARITY_EN
                        parityAcc <= 1'b0;
`endif
                    end else if (bus.SerialValid) begin
`ifdef SERIAL_RX_PARITY_EN
                        if (bitCount == PARITY_IDX) begin
                            state     <= HOLD;
                            busy      <= 1'b0;
                            wordReg   <= shiftReg;
                            wordValid <= 1'b1;
                            parityErr <= parityAcc ^ bus.SerialIn;
                        end else begin
                            shiftReg  <= shifted;
                            parityAcc <= parityAcc ^ bus.SerialIn;
                            bitCount  <= bitCount + 1'b1;
                        end
`else
                        shiftReg <= shifted;
                        bitCount <= bitCount + 1'b1;
                        if (bitCount == LAST_DATA) begin
                            state     <= HOLD;
                            busy      <= 1'b0;
                            wordReg   <= shifted;
                            wordValid <= 1'b1;
                        end
`endif
                    end
                end
                HOLD: begin
                    if (bus.WordReady) begin
                        wordValid <= 1'b0;
                        if (bus.Start) begin
                            // Accept and open the next frame together
                            state    <= SHIFT;
                            busy     <= 1'b1;
                            bitCount <= '0;
                            shiftReg <= '0;
`ifdef SERIAL_RX_PARITY_EN
                            parityAcc <= 1'b0;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end else if (bus.Start) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    wordValid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ParallelOutput = wordReg;
    assign bus.WordValid      = wordValid;
    assign bus.Busy           = busy;
    assign bus.Overrun        = overrun;
`ifdef SERIAL_RX_PARITY_EN
    assign bus.ParityError    = parityErr;
`else
    assign bus.ParityError    = 1'b0;
`endif

endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Deserializer for the shift-and-add multiplier datapath: it accepts words shifted out MSB-first from a left-shifting 16-bit register and rebuilds them into parallel words. A start strobe frames each word. A bit counter and a three-state FSM capture exactly WIDTH qualified bits. The finished word is held behind a valid/ready handshake until the consumer (product or operand register load path) accepts it.

## Interface
- WIDTH, 16, word length in bits (≥2)
- clk  in  1  rising-edge clock; sole clock
- clr  in  1  synchronous active-low reset, sampled on rising clk
- Start  in  1  frame strobe; opens a new word
- SerialIn  in  1  serial data bit, MSB first
- SerialValid  in  1  qualifies SerialIn this cycle
- WordReady  in  1  consumer accepts held word
- ParallelOutput  out  WIDTH  received word
- WordValid  out  1  ParallelOutput holds a complete word
- Busy  out  1  frame in progress (state SHIFT)
- Overrun  out  1  sticky: Start arrived while word unaccepted
- ParityError  out  1  parity check result for held word

## Operation
- States: IDLE, SHIFT, HOLD. Reset → IDLE.
- IDLE: Start=1 → SHIFT, bit counter ← 0, shift register ← 0. SerialIn in the Start cycle is discarded.
- SHIFT: each cycle with SerialValid=1: shreg ← {shreg[WIDTH-2:0], SerialIn}, counter +1. SerialValid=0 cycles hold everything (gaps legal, unbounded).
- Accepting bit index WIDTH-1 (last data bit, LSB) ends data phase: without parity → HOLD, ParallelOutput ← final shifted value, WordValid ← 1.
- Start=1 while in SHIFT: frame restarts (counter ← 0, shreg ← 0), bit that cycle discarded, Overrun unaffected.
- HOLD: ParallelOutput, WordValid, ParityError stable. WordReady=1 → WordValid ← 0, state ← IDLE next cycle; ParallelOutput keeps last word.
- Start=1 in HOLD with WordReady=0: Overrun ← 1, Start otherwise ignored. Start=1 and WordReady=1 same cycle: word accepted, go directly to SHIFT (counter/shreg cleared), no Overrun.
- Overrun clears only on reset.
- Counter width ceil(log2(WIDTH+1)); never wraps: leaves SHIFT at terminal count.
- Busy = (state == SHIFT).

## Timing
- Reset values: ParallelOutput=0, WordValid=0, Busy=0, Overrun=0, ParityError=0, state IDLE, counter 0.
- clr=0 mid-frame or in HOLD: all of the above next edge; pending word lost; clr dominates Start/WordReady.
- Start at edge n → Busy=1 from n+1. With SerialValid continuously 1 from n+1, WordValid=1 after edge n+WIDTH (no parity) or n+WIDTH+1 (parity).
- WordValid falls on the edge where WordReady=1 is sampled; minimum HOLD residency 1 cycle.
- All outputs registered; no combinational input→output path.

## Configuration
- SERIAL_RX_PARITY_EN defined: after the WIDTH data bits, SHIFT consumes one more qualified bit (even parity over data + parity bit); then HOLD with ParityError ← XOR of all WIDTH+1 bits. Parity bit not stored in ParallelOutput. Start restart rules apply during the parity bit too.
- Undefined: no parity phase; ParityError constant 0.

## Test plan
- Reset, Start, 16 consecutive valid bits of 0xA5C3 MSB-first, WordReady=1 on first WordValid → ParallelOutput=0xA5C3, WordValid high exactly 1 cycle, returns to IDLE, Busy low.
- Same word 0x8001 with SerialValid toggling 1/0 every cycle → WordValid after 32 cycles, ParallelOutput=0x8001.
- Start after 7 bits of 0xFFFF, then 16 bits of 0x1234 → ParallelOutput=0x1234, Overrun=0.
- Complete 0x00FF, hold WordReady=0, pulse Start → Overrun=1, word still 0x00FF, WordValid=1; later WordReady=1 clears WordValid, Overrun stays 1 until clr=0.
- clr=0 after 10 bits of a frame → next cycle all outputs 0, state IDLE; subsequent full frame 0x5A5A received correctly.
- With SERIAL_RX_PARITY_EN: 0x0001 + parity bit 1 → ParityError=0; 0x0001 + parity bit 0 → ParityError=1; ParallelOutput=0x0001 in both.
